// File: rtl/eth_port_arbiter.sv
// eth_port_arbiter: frame-granular round-robin arbiter sharing one parser between NUM_PORTS AXI4-Stream ports
module eth_port_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_FRAME_BEATS = 1024,
    parameter int PORT_W          = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [PORT_W-1:0]               m_axis_tid,
    output logic                            m_axis_ttrunc,
    output logic                            busy,
    output logic [15:0]                     trunc_count
);
    localparam int CNT_W = $clog2(MAX_FRAME_BEATS + 1);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [PORT_W-1:0] grant_q, grant_d, last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [15:0]       trunc_q, trunc_d;
    logic [DATA_WIDTH-1:0] src_data;
    logic              src_valid, src_last, found, at_limit, accept;
    logic [PORT_W-1:0] pick, idx;

    always_comb begin
        src_data  = '0;
        src_valid = 1'b0;
        src_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == PORT_W'(i)) begin
                src_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                src_valid = s_axis_tvalid[i];
                src_last  = s_axis_tlast[i];
            end
        end
    end

    // Search starts just after the last served port, so that port ranks lowest.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = PORT_W'((int'(last_grant_q) + i) % NUM_PORTS);
            if (!found && s_axis_tvalid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign at_limit      = beat_cnt_q == CNT_W'(MAX_FRAME_BEATS - 1);
    assign m_axis_tvalid = state_q == GRANT && src_valid;
    assign m_axis_tdata  = state_q == GRANT ? src_data : '0;
    assign m_axis_tlast  = m_axis_tvalid && (src_last || at_limit);
    assign m_axis_ttrunc = m_axis_tvalid && at_limit && !src_last;
    assign m_axis_tid    = state_q == IDLE ? '0 : grant_q;
    assign accept        = m_axis_tvalid && m_axis_tready;
    assign busy          = state_q != IDLE;
    assign trunc_count   = trunc_q;

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == PORT_W'(i))
                s_axis_tready[i] = state_q == DRAIN || (state_q == GRANT && m_axis_tready);
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        trunc_d      = trunc_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d      = pick;
                last_grant_d = pick;
                state_d      = GRANT;
            end
            GRANT: if (accept) begin
                if (src_last) begin
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end else if (at_limit) begin
                    beat_cnt_d = '0;
                    trunc_d    = trunc_q != 16'hFFFF ? trunc_q + 16'd1 : trunc_q;
                    state_d    = DRAIN;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            DRAIN: if (src_valid && src_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            beat_cnt_q   <= '0;
            trunc_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            trunc_q      <= trunc_d;
        end
    end
endmodule

// File: tb/tb_eth_port_arbiter.sv
// tb_eth_port_arbiter: directed-vector bench for eth_port_arbiter with per-port frame sources and a beat log
module tb_eth_port_arbiter;
    localparam int NP = 4;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0] s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] m_tdata;
    logic m_tvalid, m_tlast, m_tready, m_ttrunc, busy;
    logic [PW-1:0] m_tid;
    logic [15:0] trunc_count;

    always #5 clk = ~clk;

    eth_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_FRAME_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .m_axis_tid(m_tid), .m_axis_ttrunc(m_ttrunc), .busy(busy), .trunc_count(trunc_count)
    );

    int rem[NP], bidx[NP], nfr[NP], flen[NP];
    int cyc, log_n, vectors, errs, other_rdy;
    bit toggle;
    int l_tid[64], l_data[64], l_last[64], l_trunc[64], l_cyc[64];
    int busy_h[64];

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int p, input int len, input int frames);
        flen[p] = len;
        rem[p]  = len;
        nfr[p]  = frames;
        bidx[p] = 0;
    endtask

    task automatic clear_src();
        for (int p = 0; p < NP; p++) begin
            rem[p] = 0;
            nfr[p] = 0;
            bidx[p] = 0;
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = rem[p] > 0;
            s_tlast[p]  = rem[p] == 1;
            s_tdata[p*DW +: DW] = {8'(p), 8'(bidx[p])};
        end
        m_tready = toggle ? (cyc % 2 == 0) : 1'b1;
    endtask

    task automatic observe();
        if (cyc < 64) busy_h[cyc] = busy;
        if (m_tvalid && m_tready && log_n < 64) begin
            l_tid[log_n]   = m_tid;
            l_data[log_n]  = m_tdata;
            l_last[log_n]  = m_tlast;
            l_trunc[log_n] = m_ttrunc;
            l_cyc[log_n]   = cyc;
            log_n++;
        end
        if (rem[1] > 0 && (s_tready & 4'b1101) != 0) other_rdy++;
        for (int p = 0; p < NP; p++) begin
            if (s_tvalid[p] && s_tready[p]) begin
                bidx[p]++;
                rem[p]--;
                if (rem[p] == 0) begin
                    nfr[p]--;
                    if (nfr[p] > 0) begin
                        rem[p] = flen[p];
                        bidx[p] = 0;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            #1;
            observe();
            @(negedge clk);
        end
    endtask

    task automatic begin_scn();
        cyc = 0;
        log_n = 0;
        other_rdy = 0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_src();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0;
        errs = 0;
        toggle = 1'b0;
        cyc = 0;
        clear_src();
        rst_n = 1'b0;
        load(1, 2, 1);
        drive();
        #12;
        check("rst_busy", busy, 0);
        check("rst_mvalid", m_tvalid, 0);
        check("rst_sready", s_tready, 0);
        check("rst_mlast", m_tlast, 0);
        check("rst_ttrunc", m_ttrunc, 0);
        check("rst_trunc_cnt", trunc_count, 0);
        check("rst_tid", m_tid, 0);
        check("rst_tdata", m_tdata, 0);
        reset_dut();

        // single 5-beat frame from port 2
        begin_scn();
        load(2, 5, 1);
        run(8);
        check("s1_beats", log_n, 5);
        for (int i = 0; i < 5; i++) begin
            check("s1_tid", l_tid[i], 2);
            check("s1_data", l_data[i], 'h200 + i);
            check("s1_last", l_last[i], int'(i == 4));
        end
        check("s1_first_cyc", l_cyc[0], 1);
        check("s1_busy_idle0", busy_h[0], 0);
        check("s1_busy_last", busy_h[5], 1);
        check("s1_busy_after", busy_h[6], 0);

        // round robin, every port two 3-beat frames
        reset_dut();
        begin_scn();
        for (int p = 0; p < NP; p++) load(p, 3, 2);
        run(36);
        check("s2_beats", log_n, 24);
        for (int j = 0; j < 24; j++) begin
            check("s2_tid", l_tid[j], (j / 3) % 4);
            check("s2_cyc", l_cyc[j], 1 + 4 * (j / 3) + j % 3);
            check("s2_last", l_last[j], int'(j % 3 == 2));
            check("s2_data", l_data[j], (((j / 3) % 4) << 8) | (j % 3));
        end

        // backpressure toggling on a 6-beat frame from port 1
        reset_dut();
        begin_scn();
        toggle = 1'b1;
        load(1, 6, 1);
        run(1);
        load(0, 2, 1);
        load(3, 2, 1);
        run(23);
        toggle = 1'b0;
        check("s3_beats", log_n, 10);
        for (int j = 0; j < 6; j++) begin
            check("s3_tid", l_tid[j], 1);
            check("s3_data", l_data[j], 'h100 + j);
            check("s3_cyc", l_cyc[j], 2 + 2 * j);
            check("s3_last", l_last[j], int'(j == 5));
        end
        check("s3_next_tid", l_tid[6], 3);
        check("s3_next_cyc", l_cyc[6], 14);
        check("s3_next2_tid", l_tid[8], 0);
        check("s3_next2_cyc", l_cyc[8], 18);
        check("s3_other_ready", other_rdy, 0);

        // truncation: 12-beat frame with an 8-beat limit
        reset_dut();
        begin_scn();
        load(0, 12, 1);
        load(1, 2, 1);
        run(18);
        check("s4_beats", log_n, 10);
        for (int j = 0; j < 8; j++) begin
            check("s4_tid", l_tid[j], 0);
            check("s4_data", l_data[j], j);
            check("s4_last", l_last[j], int'(j == 7));
            check("s4_trunc", l_trunc[j], int'(j == 7));
            check("s4_cyc", l_cyc[j], j + 1);
        end
        check("s4_p1_tid", l_tid[8], 1);
        check("s4_p1_cyc", l_cyc[8], 14);
        check("s4_p1_data", l_data[8], 'h100);
        check("s4_p1_last", l_last[9], 1);
        check("s4_trunc_cnt", trunc_count, 1);
        check("s4_drained", rem[0], 0);
        check("s4_busy_drain", busy_h[12], 1);
        check("s4_busy_idle", busy_h[13], 0);

        // exactly MB beats: normal frame
        begin_scn();
        load(2, 8, 1);
        run(11);
        check("s5_beats", log_n, 8);
        for (int j = 0; j < 8; j++) begin
            check("s5_trunc", l_trunc[j], 0);
            check("s5_last", l_last[j], int'(j == 7));
        end
        check("s5_last_cyc", l_cyc[7], 8);
        check("s5_trunc_cnt", trunc_count, 1);
        check("s5_no_drain", busy_h[9], 0);

        // asynchronous reset on beat 3
        begin_scn();
        load(3, 6, 1);
        run(3);
        drive();
        #1;
        check("s6_pre_valid", m_tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("s6_busy", busy, 0);
        check("s6_mvalid", m_tvalid, 0);
        check("s6_sready", s_tready, 0);
        check("s6_mlast", m_tlast, 0);
        check("s6_trunc_cnt", trunc_count, 0);
        check("s6_tid", m_tid, 0);
        clear_src();
        @(negedge clk);
        rst_n = 1'b1;
        begin_scn();
        load(0, 1, 1);
        load(1, 1, 1);
        load(3, 1, 1);
        run(8);
        check("s6_beats", log_n, 3);
        check("s6_tid0", l_tid[0], 0);
        check("s6_tid1", l_tid[1], 1);
        check("s6_tid2", l_tid[2], 3);
        check("s6_cyc0", l_cyc[0], 1);
        check("s6_cyc2", l_cyc[2], 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/eth_port_arbiter.md
# eth_port_arbiter

Frame-granular round-robin arbiter that shares one `ethernet_frame_parser` instance between `NUM_PORTS` AXI4-Stream ingress ports. It sits directly upstream of the parser and grants one port at a time for a whole frame. It forwards that frame unmodified and tags every output beat with the source port index. Frames longer than `MAX_FRAME_BEATS` are cut: the arbiter forces `tlast` and discards the remainder of that frame.

## Interface
- `NUM_PORTS`, 4: number of ingress ports, 2..16.
- `DATA_WIDTH`, 64: stream data width, matches the parser.
- `MAX_FRAME_BEATS`, 1024: beat limit per frame, ≥2.
- `PORT_W`, `$clog2(NUM_PORTS)`: derived, port index width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_axis_tdata` in `NUM_PORTS*DATA_WIDTH`: per-port data, port i at slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid` in `NUM_PORTS`: per-port valid.
- `s_axis_tlast` in `NUM_PORTS`: per-port last.
- `s_axis_tready` out `NUM_PORTS`: per-port ready.
- `m_axis_tdata` out `DATA_WIDTH`: to parser.
- `m_axis_tvalid` out 1: to parser.
- `m_axis_tlast` out 1: to parser.
- `m_axis_tready` in 1: from parser.
- `m_axis_tid` out `PORT_W`: granted port index, valid whenever `m_axis_tvalid`=1.
- `m_axis_ttrunc` out 1: set on the forced-last beat of a truncated frame.
- `busy` out 1: set when the state is not IDLE.
- `trunc_count` out 16: saturating count of truncated frames.

## Operation
- The state machine has three states: IDLE, GRANT and DRAIN.
- **IDLE**
  - All `s_axis_tready`=0 and `m_axis_tvalid`=0.
  - When any `s_axis_tvalid` bit is 1, the arbiter picks the first requesting port, searching from `last_grant+1` (mod `NUM_PORTS`) upward.
  - On the next edge it registers that index into `grant` and `last_grant` and moves to GRANT.
- **GRANT**
  - Datapath is combinational from the granted port: `m_axis_tdata/tvalid/tlast` come from port `grant`, and `s_axis_tready[grant]` = `m_axis_tready`. All other ready bits are 0.
  - `m_axis_tid` = `grant`.
  - `beat_cnt` (width `$clog2(MAX_FRAME_BEATS+1)`) increments on every accepted beat (`m_axis_tvalid && m_axis_tready`).
  - Accepted beat with `tlast`=1: `beat_cnt` clears and the state goes to IDLE.
  - Accepted beat with `beat_cnt == MAX_FRAME_BEATS-1` and source `tlast`=0:
    - The beat goes out with `m_axis_tlast`=1 and `m_axis_ttrunc`=1.
    - `trunc_count` increments and saturates at 0xFFFF.
    - `beat_cnt` clears and the state goes to DRAIN.
  - If the source `tlast` is 1 on the limit beat, the frame is normal: no truncation is flagged.
- **DRAIN**
  - `s_axis_tready[grant]`=1; all other ready bits 0; `m_axis_tvalid`=0.
  - Source beats are consumed and dropped.
  - An accepted beat with `tlast`=1 moves the state to IDLE.
- **Fairness:** a port that has just been served is the lowest priority in the next arbitration, so a continuously requesting port waits at most `NUM_PORTS-1` frames.
- **Request timing:** a request that appears or disappears in the same cycle as the IDLE decision is judged on its sampled value only; no combinational re-arbitration takes place.
- **Source rule:** sources must not withdraw `tvalid` mid-frame; the arbiter keeps the grant regardless of `tvalid` gaps.

## Timing
- **Reset values:**
  - state IDLE, `grant`=0, `last_grant`=`NUM_PORTS-1` (port 0 wins first), `beat_cnt`=0, `trunc_count`=0.
  - All outputs are 0: `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `m_axis_ttrunc`, `busy`.
  - `m_axis_tdata` and `m_axis_tid` are 0 while in IDLE.
- **Arbitration latency:** a request sampled in IDLE leads to GRANT on the next edge. Its first beat can be accepted in the first GRANT cycle, which is one bubble cycle after the request is seen.
- **Inter-frame gap:** exactly one IDLE cycle between consecutive frames, including back-to-back frames from the same port.
- **Forwarding latency:** zero cycles; the data and handshake path has no register stage.
- **Backpressure:** `m_axis_tready`=0 stalls the granted port and holds all state.
- **Reset mid-frame:** state returns to IDLE immediately (asynchronously). No partial-frame recovery is attempted; upstream and the parser share `rst_n`.

## Test plan
- **Single frame:** port 2 only, 5-beat frame, `m_axis_tready`=1 → `tid`=2 on 5 beats, `tlast` on beat 5, first beat accepted 1 cycle after `tvalid`, `busy` falls one cycle after the `tlast` beat.
- **Round-robin:** all 4 ports continuously request 3-beat frames → grant order 0,1,2,3,0,1… with exactly one idle cycle between frames.
- **Backpressure:** `m_axis_tready` toggled 1/0 every cycle during a 6-beat frame from port 1 → all 6 beats delivered in order, no beat duplicated or lost, other ports' `tready` stay 0.
- **Truncation:** `MAX_FRAME_BEATS`=8, port 0 sends 12 beats → 8 beats forwarded, `tlast`+`ttrunc` on beat 8, beats 9–12 consumed and not forwarded, `trunc_count`=1, then port 1 is granted next.
- **Exact limit:** 8-beat frame with `MAX_FRAME_BEATS`=8 → `ttrunc`=0, `trunc_count` unchanged, no DRAIN.
- **Reset mid-frame:** `rst_n` asserted on beat 3 of a frame → all outputs 0 in the same cycle; after release, port 0 has priority.
